mem_arbiter: RTL

Two-port arbiter and sequencer in front of the core's single `memory` unit. It shares that unit between the instruction-fetch port and the load/store port. It drives the active-low chip-enable and request fields, and detects transaction completion from `busy`/`valid`/`load_access_fault`. It forces the one-cycle `ce` release the memory unit needs to return to IDLE between transactions. A watchdog aborts transactions that never complete.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_fault;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_fault;

    logic        mem_ce;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_memwrite;
    logic [31:0] mem_dataout;
    logic        mem_busy;
    logic        mem_valid;
    logic        mem_fault;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        input  mem_dataout, mem_busy, mem_valid, mem_fault,
        output if_ack, if_rdata, if_fault, d_ack, d_rdata, d_fault,
        output mem_ce, mem_funct3, mem_addr, mem_datain, mem_memwrite
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        output mem_dataout, mem_busy, mem_valid, mem_fault,
        input  if_ack, if_rdata, if_fault, d_ack, d_rdata, d_fault,
        input  mem_ce, mem_funct3, mem_addr, mem_datain, mem_memwrite
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory unit between fetch and load/store ports,
// with forced ce release between transactions and a completion watchdog.
module mem_arbiter #(
    parameter logic [31:0] TIMEOUT = 32'd100000
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

    state_t      state_r;
    grant_t      last_grant_r;
    logic        seen_busy_r;
    logic [31:0] timer_r;

    logic        pick_d_s;
    logic        done_s;
    logic        fault_s;
    logic [31:0] rdata_s;

    // Data port wins only when fetch is not asking or fetch was served last.
    always_comb begin
        pick_d_s = 1'b0;
        if (bus.d_req && (!bus.if_req || (last_grant_r == GRANT_IF))) begin
            pick_d_s = 1'b1;
        end else begin
            pick_d_s = 1'b0;
        end
    end

    // Completion detection; the if/else order encodes fault > valid > busy-fall > watchdog.
    always_comb begin
        done_s  = 1'b0;
        fault_s = 1'b0;
        rdata_s = 32'd0;
        if (bus.mem_fault) begin
            done_s  = 1'b1;
            fault_s = 1'b1;
        end else if (bus.mem_valid) begin
            done_s  = 1'b1;
            rdata_s = bus.mem_dataout;
        end else if (seen_busy_r && !bus.mem_busy) begin
            // GPIO and control-register reads finish this way without a valid strobe
            done_s  = 1'b1;
            rdata_s = bus.mem_memwrite ? 32'd0 : bus.mem_dataout;
        end else if ((TIMEOUT != 32'd0) && (timer_r == (TIMEOUT - 32'd1))) begin
            done_s  = 1'b1;
            fault_s = 1'b1;
        end else begin
            done_s  = 1'b0;
        end
    end

    // Transaction sequencer with all port outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= S_IDLE;
            last_grant_r     <= GRANT_D;
            seen_busy_r      <= 1'b0;
            timer_r          <= 32'd0;
            bus.mem_ce       <= 1'b1;
            bus.mem_funct3   <= 3'd0;
            bus.mem_addr     <= 32'd0;
            bus.mem_datain   <= 32'd0;
            bus.mem_memwrite <= 1'b0;
            bus.if_ack       <= 1'b0;
            bus.if_rdata     <= 32'd0;
            bus.if_fault     <= 1'b0;
            bus.d_ack        <= 1'b0;
            bus.d_rdata      <= 32'd0;
            bus.d_fault      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        if (pick_d_s) begin
                            last_grant_r     <= GRANT_D;
                            bus.mem_funct3   <= bus.d_funct3;
                            bus.mem_addr     <= bus.d_addr;
                            bus.mem_datain   <= bus.d_wdata;
                            bus.mem_memwrite <= bus.d_we;
                        end else begin
                            last_grant_r     <= GRANT_IF;
                            bus.mem_funct3   <= 3'b010;
                            bus.mem_addr     <= bus.if_addr;
                            bus.mem_datain   <= 32'd0;
                            bus.mem_memwrite <= 1'b0;
                        end
                        seen_busy_r <= 1'b0;
                        timer_r     <= 32'd0;
                        bus.mem_ce  <= 1'b0;
                        state_r     <= S_WAIT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_busy) begin
                        seen_busy_r <= 1'b1;
                    end
                    timer_r <= timer_r + 32'd1;
                    if (done_s) begin
                        if (last_grant_r == GRANT_D) begin
                            bus.d_ack   <= 1'b1;
                            bus.d_rdata <= rdata_s;
                            bus.d_fault <= fault_s;
                        end else begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= rdata_s;
                            bus.if_fault <= fault_s;
                        end
                        bus.mem_ce <= 1'b1;
                        state_r    <= S_RELEASE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_RELEASE: begin
                    bus.if_ack   <= 1'b0;
                    bus.if_rdata <= 32'd0;
                    bus.if_fault <= 1'b0;
                    bus.d_ack    <= 1'b0;
                    bus.d_rdata  <= 32'd0;
                    bus.d_fault  <= 1'b0;
                    state_r      <= S_IDLE;
                end
                default: begin
                    bus.mem_ce <= 1'b1;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
